// File: rtl/memory_access_controller.sv
// Single-word memory bus controller: accepts one CPU read/write, waits on memReady, returns one response pulse.
// Optional macro MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYCLES wait cycles with respError.
module memory_access_controller #(
    parameter int BITS_DATA      = 32,
    parameter int BITS_ADDR      = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWrite,
    input  logic [BITS_ADDR-1:0] reqAddr,
    input  logic [BITS_DATA-1:0] reqData,
    output logic                 respValid,
    output logic [BITS_DATA-1:0] respData,
    output logic                 respError,
    output logic [BITS_ADDR-1:0] memAddr,
    output logic [BITS_DATA-1:0] memWData,
    output logic                 memWrite,
    output logic                 memEnable,
    input  logic [BITS_DATA-1:0] memRData,
    input  logic                 memReady
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state_q, state_d;
    logic [BITS_ADDR-1:0]   mem_addr_q, mem_addr_d;
    logic [BITS_DATA-1:0]   mem_wdata_q, mem_wdata_d;
    logic                   mem_write_q, mem_write_d;
    logic                   mem_enable_q, mem_enable_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [BITS_DATA-1:0]   resp_data_q, resp_data_d;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   resp_error_q, resp_error_d;
`endif

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_write_d  = mem_write_q;
        mem_enable_d = mem_enable_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        resp_error_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (reqValid) begin
                    mem_addr_d   = reqAddr;
                    mem_wdata_d  = reqData;
                    mem_write_d  = reqWrite;
                    mem_enable_d = 1'b1;
                    state_d      = ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                end
            end
            ACCESS: begin
                if (memReady) begin
                    if (!mem_write_q) begin
                        resp_data_d = memRData;
                    end
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
`ifdef MEM_TIMEOUT_EN
                // The edge closing the TIMEOUT_CYCLES-th wait cycle aborts; memReady on that edge still wins.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            mem_enable_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
            resp_error_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_write_q  <= mem_write_d;
            mem_enable_q <= mem_enable_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= cnt_d;
            resp_error_q <= resp_error_d;
`endif
        end
    end

    // Reset gating keeps reqReady low while the state register is held in IDLE by reset.
    assign reqReady  = resetN && (state_q == IDLE);
    assign respValid = resp_valid_q;
    assign respData  = resp_data_q;
    assign memAddr   = mem_addr_q;
    assign memWData  = mem_wdata_q;
    assign memWrite  = mem_write_q;
    assign memEnable = mem_enable_q;
`ifdef MEM_TIMEOUT_EN
    assign respError = resp_error_q;
`else
    assign respError = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed self-checking bench for memory_access_controller: vector table plus hand sequences.
module tb_memory_access_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [15:0] reqAddr;
    logic [31:0] reqData;
    logic        respValid;
    logic [31:0] respData;
    logic        respError;
    logic [15:0] memAddr;
    logic [31:0] memWData;
    logic        memWrite;
    logic        memEnable;
    logic [31:0] memRData;
    logic        memReady;

    int tests = 0;
    int fails = 0;

    memory_access_controller #(
        .BITS_DATA(32), .BITS_ADDR(16), .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk), .resetN(resetN),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqData(reqData),
        .respValid(respValid), .respData(respData), .respError(respError),
        .memAddr(memAddr), .memWData(memWData), .memWrite(memWrite),
        .memEnable(memEnable), .memRData(memRData), .memReady(memReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction from IDLE; memReady rises in ACCESS cycle waits+1.
    task automatic do_txn(input string nm, input logic wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int waits, input logic [31:0] exp_data);
        int en_cycles;
        chk({nm, ".ready_idle"}, 32'(reqReady), 32'd1);
        reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqData = wdata;
        memRData = rdata; memReady = 1'b0;
        tick();
        reqValid = 1'b0;
        en_cycles = 0;
        for (int k = 0; k <= waits; k++) begin
            if (memEnable === 1'b1 && memAddr === addr && memWData === wdata &&
                memWrite === wr && reqReady === 1'b0 && respValid === 1'b0)
                en_cycles++;
            if (k == waits) memReady = 1'b1;
            tick();
        end
        memReady = 1'b0;
        chk({nm, ".access_cycles"}, 32'(en_cycles), 32'(waits + 1));
        chk({nm, ".resp_valid"}, 32'(respValid), 32'd1);
        chk({nm, ".resp_data"}, respData, exp_data);
        chk({nm, ".resp_error"}, 32'(respError), 32'd0);
        chk({nm, ".en_drop"}, {30'd0, memEnable, memWrite}, 32'd0);
        chk({nm, ".addr_kept"}, 32'(memAddr), 32'(addr));
        chk({nm, ".ready_resp"}, 32'(reqReady), 32'd0);
        tick();
        chk({nm, ".resp_end"}, {30'd0, respValid, respError}, 32'd0);
        chk({nm, ".ready_back"}, 32'(reqReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"rd_zero_wait", 1'b0, 16'h0010, 32'h0000_0000, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
        vecs[1] = '{"wr_wait3",     1'b1, 16'h00FF, 32'h1234_5678, 32'hAAAA_5555, 3, 32'hDEAD_BEEF};
        vecs[2] = '{"rd_ffff",      1'b0, 16'hFFFF, 32'h0000_0001, 32'h0BAD_F00D, 1, 32'h0BAD_F00D};
        vecs[3] = '{"wr_ffff",      1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'h5555_AAAA, 0, 32'h0BAD_F00D};
        vecs[4] = '{"rd_zero_data", 1'b0, 16'h1234, 32'h0000_0000, 32'h0000_0000, 2, 32'h0000_0000};

        // Reset with a request pending
        resetN = 1'b0; reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 16'hABCD;
        reqData = 32'h0101_0101; memRData = 32'h0; memReady = 1'b1;
        tick(); tick();
        chk("rst.ready", 32'(reqReady), 32'd0);
        chk("rst.mem", {29'd0, memEnable, memWrite, respValid}, 32'd0);
        chk("rst.addr", 32'(memAddr), 32'd0);
        chk("rst.wdata", memWData, 32'd0);
        chk("rst.rdata_err", {respData[30:0], respError}, 32'd0);
        #3 resetN = 1'b1;
        #1;
        chk("rst.ready_after", 32'(reqReady), 32'd1);
        chk("rst.no_early_accept", 32'(memEnable), 32'd0);
        tick();
        chk("rst.first_accept", {15'd0, memEnable, memAddr}, {15'd0, 1'b1, 16'hABCD});
        reqValid = 1'b0;
        tick();
        chk("rst.first_resp", 32'(respValid), 32'd1);
        memReady = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            do_txn(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].rdata, vecs[i].waits, vecs[i].exp_data);

        // Back-to-back with reqValid held and memReady held high
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h0100; memReady = 1'b1;
        memRData = 32'h1111_1111;
        tick();
        chk("b2b.acc1", {15'd0, memEnable, memAddr}, {15'd0, 1'b1, 16'h0100});
        chk("b2b.ready_acc", 32'(reqReady), 32'd0);
        reqAddr = 16'h0200; memRData = 32'h2222_2222;
        tick();
        chk("b2b.resp1", {30'd0, respValid, memEnable}, 32'd2);
        chk("b2b.resp1_data", respData, 32'h2222_2222);
        chk("b2b.ready_resp", 32'(reqReady), 32'd0);
        tick();
        chk("b2b.idle", {29'd0, reqReady, memEnable, respValid}, 32'd4);
        tick();
        chk("b2b.acc2", {15'd0, memEnable, memAddr}, {15'd0, 1'b1, 16'h0200});
        reqValid = 1'b0; memRData = 32'h3333_3333;
        tick();
        chk("b2b.resp2", {30'd0, respValid, memEnable}, 32'd2);
        chk("b2b.resp2_data", respData, 32'h3333_3333);
        memReady = 1'b0;
        tick();

        // Reset pulse in the second ACCESS cycle of a write
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 16'h0030; reqData = 32'h4444_4444;
        tick();
        reqValid = 1'b0;
        tick();
        chk("mrst.access2", {30'd0, memEnable, memWrite}, 32'd3);
        #2 resetN = 1'b0;
        #1;
        chk("mrst.drop", {29'd0, memEnable, memWrite, respValid}, 32'd0);
        chk("mrst.ready", 32'(reqReady), 32'd0);
        #1 resetN = 1'b1;
        memReady = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (respValid !== 1'b0 || memEnable !== 1'b0) seen++;
            end
            chk("mrst.no_resp", 32'(seen), 32'd0);
        end
        memReady = 1'b0;
        do_txn("post_rst_rd", 1'b0, 16'h0020, 32'h0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);

`ifdef MEM_TIMEOUT_EN
        // memReady never arrives: abort after 15 ACCESS cycles
        begin
            int en_cycles = 0;
            int done = 0;
            reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h0040; memRData = 32'h7777_7777;
            tick();
            reqValid = 1'b0;
            for (int k = 0; k < 40 && done == 0; k++) begin
                if (respValid === 1'b1) done = 1;
                else begin
                    if (memEnable === 1'b1) en_cycles++;
                    tick();
                end
            end
            chk("to.cycles", 32'(en_cycles), 32'd15);
            chk("to.valid_err", {30'd0, respValid, respError}, 32'd3);
            chk("to.data_kept", respData, 32'hCAFE_F00D);
            chk("to.en_drop", 32'(memEnable), 32'd0);
            tick();
            chk("to.err_clear", {30'd0, respValid, respError}, 32'd0);
        end
        do_txn("to.ready_on_15", 1'b0, 16'h0041, 32'h0, 32'h89AB_CDEF, 14, 32'h89AB_CDEF);
`else
        // Without the timeout the access waits indefinitely
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h0040; memRData = 32'h7777_7777;
        tick();
        reqValid = 1'b0;
        begin
            int bad = 0;
            for (int k = 0; k < 30; k++) begin
                if (memEnable !== 1'b1 || respValid !== 1'b0 || respError !== 1'b0) bad++;
                tick();
            end
            chk("nto.wait_forever", 32'(bad), 32'd0);
        end
        memReady = 1'b1;
        tick();
        memReady = 1'b0;
        chk("nto.late_resp", {30'd0, respValid, respError}, 32'd2);
        chk("nto.late_data", respData, 32'h7777_7777);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
